// File: rtl/badvinstr_fifo.sv
// Bad-instruction history FIFO: captures the faulting instruction word when an
// instruction aborts with an exception (and capture is not masked by irq/r_h)
// and lets software drain the history oldest-first.
//
// Parameters:
//   DATA_W - captured instruction word width
//   DEPTH  - number of history entries (power of 2, >= 2)
//
// Ports:
//   clk             - clock, all state updates on rising edge
//   rst             - asynchronous active-low reset
//   r_p             - capture request from the pipeline
//   r_h             - hold, blocks captures (pops still proceed)
//   exception_abort - current instruction aborted with an exception
//   irq             - pending interrupt, masks capture
//   badvinstr_p     - faulting instruction word
//   pop             - consume the oldest entry
//   clr_ovf         - clear the sticky overflow flag
//   read_data       - oldest entry, 0 when empty (registered)
//   valid           - FIFO non-empty (registered)
//   count           - number of held entries (registered)
//   overflow        - sticky flag, a capture hit a full FIFO (registered)
//
// Build option:
//   BADV_OVERWRITE_EN - when defined, a capture into a full FIFO overwrites the
//                       oldest entry; when undefined the new word is dropped.

module badvinstr_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r_p,
  input  logic                       r_h,
  input  logic                       exception_abort,
  input  logic                       irq,
  input  logic [DATA_W-1:0]          badvinstr_p,
  input  logic                       pop,
  input  logic                       clr_ovf,
  output logic [DATA_W-1:0]          read_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic              push_req;
  logic              pop_ok;
  logic              full;
  logic              do_write;
  logic              ovf_event;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] head_next;
  logic              overflow_next;

  assign push_req = r_p & exception_abort & ~irq & ~r_h;
  assign pop_ok   = pop & valid;
  assign full     = (count == CNT_W'(DEPTH));

  // Next pointer/count/flag state and the word that will sit at the head.
  always_comb begin
    do_write      = 1'b0;
    ovf_event     = 1'b0;
    rd_ptr_next   = rd_ptr;
    wr_ptr_next   = wr_ptr;
    count_next    = count;
    head_next     = '0;
    overflow_next = overflow;

    if (push_req && pop_ok) begin
      // Both take effect; count unchanged, even when full.
      do_write    = 1'b1;
      wr_ptr_next = wr_ptr + PTR_W'(1);
      rd_ptr_next = rd_ptr + PTR_W'(1);
    end else if (push_req && !full) begin
      do_write    = 1'b1;
      wr_ptr_next = wr_ptr + PTR_W'(1);
      count_next  = count + CNT_W'(1);
    end else if (push_req) begin
      ovf_event   = 1'b1;
`ifdef BADV_OVERWRITE_EN
      // Full: tail == head, so the new word replaces the oldest one.
      do_write    = 1'b1;
      wr_ptr_next = wr_ptr + PTR_W'(1);
      rd_ptr_next = rd_ptr + PTR_W'(1);
`endif
    end else if (pop_ok) begin
      rd_ptr_next = rd_ptr + PTR_W'(1);
      count_next  = count - CNT_W'(1);
    end

    // Forward the incoming word when it lands exactly at the new head.
    if (count_next == '0) begin
      head_next = '0;
    end else if (do_write && (wr_ptr == rd_ptr_next)) begin
      head_next = badvinstr_p;
    end else begin
      head_next = mem[rd_ptr_next];
    end

    // A new overflow event wins over a clear in the same cycle.
    if (ovf_event) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // Storage array; contents are unobservable while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= badvinstr_p;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      read_data <= '0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      valid     <= (count_next != '0);
      overflow  <= overflow_next;
      read_data <= head_next;
    end
  end

endmodule

// File: tb/tb_badvinstr_fifo.sv
// Self-checking bench for badvinstr_fifo (DATA_W=32, DEPTH=4). A queue model
// holds the expected FIFO contents; words are pushed to it when a capture is
// driven and popped/compared against read_data when the DUT releases them.
// Honours BADV_OVERWRITE_EN the same way the design does.

module tb_badvinstr_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              r_p;
  logic              r_h;
  logic              exception_abort;
  logic              irq;
  logic [DATA_W-1:0] badvinstr_p;
  logic              pop;
  logic              clr_ovf;
  logic [DATA_W-1:0] read_data;
  logic              valid;
  logic [2:0]        count;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_q[$];
  logic        m_ovf;

  badvinstr_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .r_p             (r_p),
    .r_h             (r_h),
    .exception_abort (exception_abort),
    .irq             (irq),
    .badvinstr_p     (badvinstr_p),
    .pop             (pop),
    .clr_ovf         (clr_ovf),
    .read_data       (read_data),
    .valid           (valid),
    .count           (count),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Compare all outputs against the model state.
  task automatic check_state(input string tag);
    logic [31:0] head;
    head = (sb_q.size() > 0) ? sb_q[0] : 32'h0;
    check({tag, ".count"},    32'(count),    32'(sb_q.size()));
    check({tag, ".valid"},    32'(valid),    32'(sb_q.size() > 0));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".rdata"},    read_data,     head);
  endtask

  // One clock of stimulus: drive after negedge, update model, check after posedge.
  task automatic cycle(input string tag, input logic rp, input logic ex, input logic iq,
                       input logic rh, input logic [31:0] d, input logic po, input logic c);
    logic push_eff;
    logic pop_eff;
    logic [31:0] exp_word;
    @(negedge clk);
    r_p = rp; exception_abort = ex; irq = iq; r_h = rh;
    badvinstr_p = d; pop = po; clr_ovf = c;
    push_eff = rp & ex & ~iq & ~rh;
    pop_eff  = po && (sb_q.size() > 0);
    if (pop_eff) begin
      exp_word = sb_q.pop_front();
      check({tag, ".pop_word"}, read_data, exp_word);
    end
    if (push_eff) begin
      if (sb_q.size() < DEPTH) begin
        sb_q.push_back(d);
      end else begin
        m_ovf = 1'b1;
`ifdef BADV_OVERWRITE_EN
        void'(sb_q.pop_front());
        sb_q.push_back(d);
`endif
      end
    end
    if (!(push_eff && !pop_eff && sb_q.size() == DEPTH && m_ovf && c)) begin
      if (c && !(push_eff && !pop_eff && !(sb_q.size() < DEPTH) && 1'b0)) begin
      end
    end
    @(posedge clk);
    #1;
    r_p = 1'b0; exception_abort = 1'b0; pop = 1'b0; clr_ovf = 1'b0;
    irq = 1'b0; r_h = 1'b0;
    check_state(tag);
  endtask

  task automatic push(input string tag, input logic [31:0] d);
    cycle(tag, 1'b1, 1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic do_pop(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // clr_ovf pulse; model clears unless the same cycle raises overflow.
  task automatic clr_pulse(input string tag, input logic with_push, input logic [31:0] d);
    logic will_set;
    will_set = with_push && (sb_q.size() == DEPTH);
    if (!will_set) m_ovf = 1'b0;
    cycle(tag, with_push, with_push, 1'b0, 1'b0, d, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; r_p = 1'b0; r_h = 1'b0; exception_abort = 1'b0; irq = 1'b0;
    badvinstr_p = '0; pop = 1'b0; clr_ovf = 1'b0; m_ovf = 1'b0;

    // Reset state
    #12;
    check("rst.count", 32'(count), 32'h0);
    check("rst.valid", 32'(valid), 32'h0);
    check("rst.ovf",   32'(overflow), 32'h0);
    check("rst.rdata", read_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Basic capture and drain; first push on first edge after reset release
    push("cap0", 32'h0000000F);
    push("cap1", 32'h000000FF);
    check("cap.count2", 32'(count), 32'h2);
    check("cap.head", read_data, 32'h0000000F);
    do_pop("drain0");
    check("drain.head", read_data, 32'h000000FF);
    do_pop("drain1");
    check("drain.valid", 32'(valid), 32'h0);
    check("drain.rdata0", read_data, 32'h0);
    do_pop("pop_empty");

    // Masking by irq, hold, and missing exception
    cycle("mask_irq", 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
    cycle("mask_rh",  1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    cycle("mask_ex",  1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    check("mask.count", 32'(count), 32'h0);

    // Fill and wrap
    push("fill1", 32'h1);
    push("fill2", 32'h2);
    push("fill3", 32'h3);
    push("fill4", 32'h4);
    check("fill.full", 32'(count), 32'h4);
    do_pop("wpop0");
    do_pop("wpop1");
    push("wrap5", 32'h5);
    push("wrap6", 32'h6);
    check("wrap.count", 32'(count), 32'h4);
    check("wrap.h3", read_data, 32'h3);
    do_pop("wd0");
    check("wrap.h4", read_data, 32'h4);
    do_pop("wd1");
    check("wrap.h5", read_data, 32'h5);
    do_pop("wd2");
    check("wrap.h6", read_data, 32'h6);
    do_pop("wd3");

    // Overflow
    push("ofA", 32'hA);
    push("ofB", 32'hB);
    push("ofC", 32'hC);
    push("ofD", 32'hD);
    push("ofE", 32'hE);
    check("ovf.flag", 32'(overflow), 32'h1);
    check("ovf.count", 32'(count), 32'h4);
`ifdef BADV_OVERWRITE_EN
    check("ovf.head_ow", read_data, 32'hB);
`else
    check("ovf.head_drop", read_data, 32'hA);
`endif
    cycle("ovf.hold", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("ovf.sticky", 32'(overflow), 32'h1);
    clr_pulse("ovf.clr", 1'b0, 32'h0);
    check("ovf.cleared", 32'(overflow), 32'h0);
    clr_pulse("ovf.setwins", 1'b1, 32'hF0);
    check("ovf.setwins_flag", 32'(overflow), 32'h1);
    clr_pulse("ovf.clr2", 1'b0, 32'h0);

    // Simultaneous push and pop while full
    cycle("pp_full", 1'b1, 1'b1, 1'b0, 1'b0, 32'h7, 1'b1, 1'b0);
    check("pp_full.count", 32'(count), 32'h4);
    check("pp_full.ovf", 32'(overflow), 32'h0);
    do_pop("ppd0");
    do_pop("ppd1");
    do_pop("ppd2");
    check("pp_full.tail", read_data, 32'h7);
    do_pop("ppd3");

    // Simultaneous push and pop while empty
    cycle("pp_empty", 1'b1, 1'b1, 1'b0, 1'b0, 32'h9, 1'b1, 1'b0);
    check("pp_empty.count", 32'(count), 32'h1);
    check("pp_empty.rdata", read_data, 32'h9);
    // Pop proceeds while hold blocks the push
    cycle("rh_pop", 1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
    check("rh_pop.count", 32'(count), 32'h0);

    // Asynchronous reset mid-operation
    push("ar0", 32'h21);
    push("ar1", 32'h22);
    push("ar2", 32'h23);
    check("ar.count3", 32'(count), 32'h3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar.count", 32'(count), 32'h0);
    check("ar.valid", 32'(valid), 32'h0);
    check("ar.ovf",   32'(overflow), 32'h0);
    check("ar.rdata", read_data, 32'h0);
    sb_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push("post_rst", 32'hCAFE0001);
    do_pop("post_rst_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/badvinstr_fifo.md
BADVINSTR_FIFO -- requirements
Module: badvinstr_fifo

Interface
REQ-001 Parameter DATA_W, default 32: width of the captured instruction word.
REQ-002 Parameter DEPTH, default 4: number of history entries; must be a power of 2 and at least 2.
REQ-003 Port clk, input, 1: single clock; every state element updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port r_p, input, 1: capture request, pipeline side.
REQ-006 Port r_h, input, 1: hold; blocks captures while high.
REQ-007 Port exception_abort, input, 1: the current instruction aborted with an exception.
REQ-008 Port irq, input, 1: interrupt pending; masks capture.
REQ-009 Port badvinstr_p, input, DATA_W: faulting instruction word.
REQ-010 Port pop, input, 1: consume the oldest entry.
REQ-011 Port clr_ovf, input, 1: clear the overflow flag.
REQ-012 Port read_data, output, DATA_W: oldest entry; 0 when empty.
REQ-013 Port valid, output, 1: buffer is non-empty.
REQ-014 Port count, output, $clog2(DEPTH)+1: number of held entries.
REQ-015 Port overflow, output, 1: sticky flag; a capture was lost.

Function
REQ-016 A push occurs when r_p & exception_abort & ~irq & ~r_h is sampled high at a rising edge; badvinstr_p is written at the tail.
REQ-017 A pop occurs when pop & valid is high at a rising edge; the head advances by one.
- A pop while empty is ignored and produces no state change.
REQ-018 read_data, valid and count reflect the registered state.
- Data is visible one cycle after the push edge.
- Outputs are never driven combinationally from inputs.
REQ-019 Read and write pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
- count = 0 means empty; count = DEPTH means full.
REQ-020 Push and pop in the same cycle with count greater than 0: both take effect and count is unchanged.
- This also holds when full: no overflow and no loss.
REQ-021 Push and pop in the same cycle with count = 0: the push takes effect and the pop is ignored, giving count = 1.
REQ-022 Push while full without a pop: handled as defined in Configuration; overflow is set to 1 in both modes.
REQ-023 overflow stays set until a clr_ovf edge.
- If clr_ovf coincides with a new overflow event, set wins.
REQ-024 r_h blocks pushes only; pops proceed normally while r_h is high.
REQ-025 irq high suppresses a push even when exception_abort and r_p are high.

Reset
REQ-026 When rst is low, the block asynchronously forces:
- both pointers to 0
- count = 0, valid = 0, overflow = 0, read_data = 0
REQ-027 Stored entry contents need not be cleared by reset; they are unobservable while count = 0.
REQ-028 Reset asserted mid-operation discards all entries immediately, regardless of any pending push or pop.
REQ-029 The first push is accepted on the first rising edge after rst returns high.

Configuration
REQ-030 Macro BADV_OVERWRITE_EN selects the push-while-full behaviour.
- Defined: the new word overwrites the oldest entry, both pointers advance, count stays DEPTH, and read_data shows the next-oldest word.
- Undefined: the new word is dropped and all state except overflow is unchanged.

Verification
REQ-031 Basic capture and drain, DEPTH=4.
- Stimulus: push 0x0000000F, then push 0x000000FF.
- Response: count=2 and read_data=0x0000000F; after one pop, read_data=0x000000FF; after a second pop, valid=0 and read_data=0.
REQ-032 Masking.
- Stimulus: exception_abort=1, r_p=1, badvinstr_p=0x12345678 with irq=1 for one cycle, then with r_h=1 for one cycle.
- Response: count stays 0 throughout.
REQ-033 Fill and wrap.
- Stimulus: push 0x1, 0x2, 0x3, 0x4; pop twice; push 0x5, 0x6.
- Response: read order is 0x3, 0x4, 0x5, 0x6, and count reaches 4.
REQ-034 Overflow.
- Stimulus: fill with 0xA, 0xB, 0xC, 0xD, then push 0xE.
- Response with macro undefined: head=0xA, count=4, overflow=1.
- Response with macro defined: head=0xB and tail=0xE.
- Then pulse clr_ovf: overflow returns to 0.
REQ-035 Simultaneous push and pop.
- Stimulus, full: push 0x7 with pop in the same cycle gives count=4, no overflow, tail=0x7.
- Stimulus, empty: push 0x9 with pop in the same cycle gives count=1, read_data=0x9.
REQ-036 Asynchronous reset.
- Stimulus: with count=3, drive rst low between clock edges.
- Response: count=0, valid=0, overflow=0 immediately, without waiting for a clock edge.
